// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types, default parameters and helpers for the register file bank.
package reg_file_pkg;

    typedef enum logic {
        DBG_IDLE,
        DBG_SCAN
    } dbg_state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 3;
    localparam int DEF_N_RD    = 2;
    localparam int DEF_ZERO_R0 = 0;
    localparam int DEF_BYPASS  = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/reg_file_dbg_scan.sv
// reg_file_dbg_scan: walks every register in order and presents each one as a
// valid/ready beat holding a snapshot taken when the beat was loaded.
module reg_file_dbg_scan
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] val_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] idx_o,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    dbg_state_e        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;

    // Register whose post-edge value the parent must supply for the next load.
    assign addr_o = (state_q == DBG_IDLE) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DBG_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (state_q == DBG_IDLE) begin
            if (start_i) begin
                state_q <= DBG_SCAN;
                idx_q   <= '0;
                data_q  <= val_i;
                valid_q <= 1'b1;
                busy_q  <= 1'b1;
            end
        end else if (ready_i) begin
            if (idx_q == LAST) begin
                state_q <= DBG_IDLE;
                idx_q   <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                idx_q  <= idx_q + 1'b1;
                data_q <= val_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign idx_o   = idx_q;
    assign data_o  = data_q;

endmodule

// File: rtl/reg_file_bank.sv
// reg_file_bank: parametrised register file with one write port, N_RD combinational
// read ports, optional zero register and write bypass, plus a handshaked debug scan.
module reg_file_bank
    import reg_file_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int N_RD    = DEF_N_RD,
    parameter int ZERO_R0 = DEF_ZERO_R0,
    parameter int BYPASS  = DEF_BYPASS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      wa,
    input  logic [DATA_W-1:0]      wd,
    input  logic [N_RD*ADDR_W-1:0] ra,
    output logic [N_RD*DATA_W-1:0] rd,
    input  logic                   dbg_start,
    input  logic                   dbg_ready,
    output logic                   dbg_valid,
    output logic [ADDR_W-1:0]      dbg_idx,
    output logic [DATA_W-1:0]      dbg_data,
    output logic                   dbg_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    if (N_RD < 1 || N_RD > 4 || clog2(DEPTH) != ADDR_W) begin : g_bad_params
        $error("reg_file_bank: unsupported parameter combination");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_val;

    assign wr_en = we && !(ZERO_R0 != 0 && wa == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wa] <= wd;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = ra[k*ADDR_W +: ADDR_W];
        assign rd[k*DATA_W +: DATA_W] = (ZERO_R0 != 0 && a == '0) ? '0 :
                                        (BYPASS != 0 && wr_en && wa == a) ? wd : mem_q[a];
    end

    // Post-edge value: includes a write landing on the same edge the scan loads.
    assign scan_val = (ZERO_R0 != 0 && scan_addr == '0) ? '0 :
                      (wr_en && wa == scan_addr) ? wd : mem_q[scan_addr];

    reg_file_dbg_scan #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .start_i(dbg_start),
        .ready_i(dbg_ready),
        .val_i  (scan_val),
        .addr_o (scan_addr),
        .valid_o(dbg_valid),
        .busy_o (dbg_busy),
        .idx_o  (dbg_idx),
        .data_o (dbg_data)
    );

endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: self-checking bench for reg_file_bank; dut_a uses the default
// parameters, dut_z shares its inputs with ZERO_R0=1 and BYPASS=0.
module tb_reg_file_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [2:0]  wa = '0;
    logic [7:0]  wd = '0;
    logic [5:0]  ra = '0;
    logic        dbg_start = 1'b0;
    logic        dbg_ready = 1'b0;
    logic [15:0] rd_a, rd_z;
    logic        valid_a, busy_a, valid_z, busy_z;
    logic [2:0]  idx_a, idx_z;
    logic [7:0]  data_a, data_z;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] da;
        logic [7:0] dz;
    } beat_t;

    beat_t sb[$];

    always #5 clk = ~clk;

    reg_file_bank dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a),
        .dbg_start(dbg_start), .dbg_ready(dbg_ready), .dbg_valid(valid_a),
        .dbg_idx(idx_a), .dbg_data(data_a), .dbg_busy(busy_a)
    );

    reg_file_bank #(.ZERO_R0(1), .BYPASS(0)) dut_z (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_z),
        .dbg_start(dbg_start), .dbg_ready(dbg_ready), .dbg_valid(valid_z),
        .dbg_idx(idx_z), .dbg_data(data_z), .dbg_busy(busy_z)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0 || idx_a !== 3'd0 || data_a !== 8'h00) begin
            failures++;
            $display("FAIL reset_dbg: valid=%b busy=%b idx=%0d data=%h, want 0 0 0 00", valid_a, busy_a, idx_a, data_a);
        end
        for (int i = 0; i < 8; i++) begin
            ra = {3'(7 - i), 3'(i)};
            #1;
            checks++;
            if (rd_a !== 16'h0000 || rd_z !== 16'h0000) begin
                failures++;
                $display("FAIL reset_rd[%0d]: rd_a=%h rd_z=%h, want 0000", i, rd_a, rd_z);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        we = 1'b1; wa = 3'd3; wd = 8'h5A; ra = {3'd4, 3'd3};
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (rd_a[7:0] !== 8'h5A || rd_a[15:8] !== 8'h00) begin
            failures++;
            $display("FAIL write_read: rd0=%h rd1=%h, want 5a 00", rd_a[7:0], rd_a[15:8]);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; wa = 3'd2; wd = 8'h77; ra = {3'd3, 3'd2};
        #1;
        checks++;
        if (rd_a[7:0] !== 8'h77) begin
            failures++;
            $display("FAIL bypass_same_cycle: rd0=%h, want 77", rd_a[7:0]);
        end
        checks++;
        if (rd_z[7:0] !== 8'h00) begin
            failures++;
            $display("FAIL no_bypass_old: rd0=%h, want 00", rd_z[7:0]);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (rd_z[7:0] !== 8'h77 || rd_a[7:0] !== 8'h77) begin
            failures++;
            $display("FAIL write_next_cycle: rd_a0=%h rd_z0=%h, want 77 77", rd_a[7:0], rd_z[7:0]);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        we = 1'b1; wa = 3'd0; wd = 8'hFF; ra = {3'd3, 3'd0};
        #1;
        checks++;
        if (rd_z[7:0] !== 8'h00 || rd_z[15:8] !== 8'h5A || rd_a[7:0] !== 8'hFF) begin
            failures++;
            $display("FAIL zero_same: rd_z0=%h rd_z1=%h rd_a0=%h, want 00 5a ff", rd_z[7:0], rd_z[15:8], rd_a[7:0]);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (rd_z[7:0] !== 8'h00 || rd_a[7:0] !== 8'hFF) begin
            failures++;
            $display("FAIL zero_next: rd_z0=%h rd_a0=%h, want 00 ff", rd_z[7:0], rd_a[7:0]);
        end
    endtask

    task automatic run_scan(input bit stall);
        int stall_cnt;
        stall_cnt = 0;
        for (int n = 0; n < 60 && sb.size() > 0; n++) begin
            @(negedge clk);
            dbg_start = 1'b0;
            if (valid_a) begin
                checks++;
                if (idx_a !== sb[0].idx || data_a !== sb[0].da || busy_a !== 1'b1) begin
                    failures++;
                    $display("FAIL scan_beat_a: idx=%0d data=%h busy=%b, want %0d %h 1", idx_a, data_a, busy_a, sb[0].idx, sb[0].da);
                end
                checks++;
                if (valid_z !== 1'b1 || idx_z !== sb[0].idx || data_z !== sb[0].dz) begin
                    failures++;
                    $display("FAIL scan_beat_z: valid=%b idx=%0d data=%h, want 1 %0d %h", valid_z, idx_z, data_z, sb[0].idx, sb[0].dz);
                end
                if (stall && idx_a == 3'd4 && stall_cnt < 3) begin
                    dbg_ready = 1'b0; we = (stall_cnt == 1); wa = 3'd4; wd = 8'hEE;
                    stall_cnt++;
                end else if (stall && idx_a == 3'd4) begin
                    dbg_ready = 1'b1; we = 1'b1; wa = 3'd5; wd = 8'hAB;
                end else begin
                    dbg_ready = 1'b1; we = 1'b0;
                end
                if (dbg_ready) void'(sb.pop_front());
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scan_timeout: %0d beats outstanding, want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        we = 1'b0;
        checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0 || idx_a !== 3'd0) begin
            failures++;
            $display("FAIL scan_end: valid=%b busy=%b idx=%0d, want 0 0 0", valid_a, busy_a, idx_a);
        end
    endtask

    task automatic test_full_scan();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 3'(i); wd = 8'(8'h10 + i);
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 8; i++)
            sb.push_back('{idx: 3'(i), da: 8'(8'h10 + i), dz: (i == 0) ? 8'h00 : 8'(8'h10 + i)});
        dbg_start = 1'b1; dbg_ready = 1'b1;
        run_scan(1'b0);
    endtask

    task automatic test_stall();
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            e = (i == 5) ? 8'hAB : 8'(8'h10 + i);
            sb.push_back('{idx: 3'(i), da: e, dz: (i == 0) ? 8'h00 : e});
        end
        @(negedge clk);
        dbg_start = 1'b1; dbg_ready = 1'b1;
        run_scan(1'b1);
        ra = {3'd5, 3'd4};
        #1;
        checks++;
        if (rd_a !== 16'hABEE) begin
            failures++;
            $display("FAIL stall_writes: rd_a=%h, want abee", rd_a);
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        @(negedge clk);
        dbg_start = 1'b1; dbg_ready = 1'b1;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (i == 18) dbg_start = 1'b0;
            exp = (i <= 8) || (i >= 10 && i <= 17);
            checks++;
            if (valid_a !== exp || busy_a !== exp) begin
                failures++;
                $display("FAIL back_to_back[%0d]: valid=%b busy=%b, want %b", i, valid_a, busy_a, exp);
            end
            if (i == 10) begin
                checks++;
                if (idx_a !== 3'd0 || data_a !== 8'h10) begin
                    failures++;
                    $display("FAIL back_to_back_first: idx=%0d data=%h, want 0 10", idx_a, data_a);
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        bit hit;
        hit = 1'b0;
        @(negedge clk);
        dbg_start = 1'b1; dbg_ready = 1'b1;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk);
            dbg_start = 1'b0;
            hit = valid_a && idx_a == 3'd5;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL mid_scan_reach: idx=%0d valid=%b, want 5 1", idx_a, valid_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0 || idx_a !== 3'd0 || valid_z !== 1'b0) begin
            failures++;
            $display("FAIL mid_scan_reset: valid=%b busy=%b idx=%0d valid_z=%b, want 0 0 0 0", valid_a, busy_a, idx_a, valid_z);
        end
        for (int i = 0; i < 8; i++) begin
            ra = {3'(7 - i), 3'(i)};
            #1;
            checks++;
            if (rd_a !== 16'h0000 || rd_z !== 16'h0000) begin
                failures++;
                $display("FAIL mid_scan_rd[%0d]: rd_a=%h rd_z=%h, want 0000", i, rd_a, rd_z);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero();
        test_full_scan();
        test_stall();
        test_back_to_back();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
